// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB pipeline registers around a 1-cycle data SRAM.
// Aligns load/store data, raises address errors, hands a bundle to WB.
module mem_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_store_data,
   input  logic [3:0]        ex_mem_op,
   input  logic [REG_AW-1:0] ex_write_reg,
   input  logic              ex_regwrite,
   input  logic              stall,
   input  logic              flush,
   output logic              data_sram_en,
   output logic [3:0]        data_sram_wen,
   output logic [DATA_W-1:0] data_sram_addr,
   output logic [DATA_W-1:0] data_sram_wdata,
   input  logic [DATA_W-1:0] data_sram_rdata,
   output logic [DATA_W-1:0] m_fwd_result,
   output logic              m_is_load,
   output logic              wb_valid,
   output logic              wb_regwrite,
   output logic [REG_AW-1:0] wb_write_reg,
   output logic [DATA_W-1:0] wb_result,
   output logic              exc_adel,
   output logic              exc_ades,
   output logic [DATA_W-1:0] exc_badvaddr
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   logic              m_valid_q, m_valid_d;
   logic [DATA_W-1:0] m_alu_q, m_alu_d;
   logic [DATA_W-1:0] m_data_q, m_data_d;
   logic [3:0]        m_op_q, m_op_d;
   logic [REG_AW-1:0] m_reg_q, m_reg_d;
   logic              m_rw_q, m_rw_d;

   logic              w_valid_q, w_valid_d;
   logic              w_rw_q, w_rw_d;
   logic [REG_AW-1:0] w_reg_q, w_reg_d;
   logic [DATA_W-1:0] w_alu_q, w_alu_d;
   logic [3:0]        w_op_q, w_op_d;
   logic [1:0]        w_lane_q, w_lane_d;
   logic              w_adel_q, w_adel_d;
   logic              w_ades_q, w_ades_d;

   logic              m_is_ld, m_is_st, m_mis, m_acc;
   logic [7:0]        rd_b;
   logic [15:0]       rd_h;

   // Next MEM contents: flush bubbles, stall holds, else capture EX.
   always_comb begin
      m_valid_d = m_valid_q;
      m_alu_d   = m_alu_q;
      m_data_d  = m_data_q;
      m_op_d    = m_op_q;
      m_reg_d   = m_reg_q;
      m_rw_d    = m_rw_q;
      if (flush) begin
         m_valid_d = 1'b0;
         m_alu_d   = '0;
         m_data_d  = '0;
         m_op_d    = '0;
         m_reg_d   = '0;
         m_rw_d    = 1'b0;
      end else if (!stall) begin
         m_valid_d = ex_valid;
         m_alu_d   = ex_alu_result;
         m_data_d  = ex_store_data;
         m_op_d    = ex_mem_op;
         m_reg_d   = ex_write_reg;
         m_rw_d    = ex_regwrite;
      end
   end

   // EX/MEM pipeline register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         m_valid_q <= 1'b0;
         m_alu_q   <= '0;
         m_data_q  <= '0;
         m_op_q    <= '0;
         m_reg_q   <= '0;
         m_rw_q    <= 1'b0;
      end else begin
         m_valid_q <= m_valid_d;
         m_alu_q   <= m_alu_d;
         m_data_q  <= m_data_d;
         m_op_q    <= m_op_d;
         m_reg_q   <= m_reg_d;
         m_rw_q    <= m_rw_d;
      end
   end

   // Classify the MEM op and check its address alignment.
   always_comb begin
      m_is_ld = 1'b0;
      m_is_st = 1'b0;
      m_mis   = 1'b0;
      case (m_op_q)
         OP_LB, OP_LBU: m_is_ld = 1'b1;
         OP_LH, OP_LHU: begin
            m_is_ld = 1'b1;
            m_mis   = m_alu_q[0];
         end
         OP_LW: begin
            m_is_ld = 1'b1;
            m_mis   = |m_alu_q[1:0];
         end
         OP_SB: m_is_st = 1'b1;
         OP_SH: begin
            m_is_st = 1'b1;
            m_mis   = m_alu_q[0];
         end
         OP_SW: begin
            m_is_st = 1'b1;
            m_mis   = |m_alu_q[1:0];
         end
         default: ;
      endcase
   end

   assign m_acc = m_valid_q & (m_is_ld | m_is_st) & ~m_mis & ~stall;

   // SRAM request: lane-replicated store data and byte enables.
   always_comb begin
      data_sram_en    = m_acc;
      data_sram_wen   = 4'b0000;
      data_sram_addr  = '0;
      data_sram_wdata = '0;
      if (m_acc) begin
         data_sram_addr = {m_alu_q[DATA_W-1:2], 2'b00};
         case (m_op_q)
            OP_SB: begin
               data_sram_wen   = 4'b0001 << m_alu_q[1:0];
               data_sram_wdata = {4{m_data_q[7:0]}};
            end
            OP_SH: begin
               data_sram_wen   = m_alu_q[1] ? 4'b1100 : 4'b0011;
               data_sram_wdata = {2{m_data_q[15:0]}};
            end
            OP_SW: begin
               data_sram_wen   = 4'b1111;
               data_sram_wdata = m_data_q;
            end
            default: ;
         endcase
      end
   end

   assign m_fwd_result = m_alu_q;
   assign m_is_load    = m_valid_q & m_is_ld;

   // Next WB contents: a stall sends a bubble downstream.
   always_comb begin
      w_valid_d = 1'b0;
      w_rw_d    = 1'b0;
      w_reg_d   = '0;
      w_alu_d   = '0;
      w_op_d    = '0;
      w_lane_d  = '0;
      w_adel_d  = 1'b0;
      w_ades_d  = 1'b0;
      if (!stall) begin
         w_valid_d = m_valid_q;
         w_rw_d    = m_valid_q & m_rw_q & ~m_mis;
         w_reg_d   = m_reg_q;
         w_alu_d   = m_alu_q;
         w_op_d    = m_op_q;
         w_lane_d  = m_alu_q[1:0];
         w_adel_d  = m_valid_q & m_is_ld & m_mis;
         w_ades_d  = m_valid_q & m_is_st & m_mis;
      end
   end

   // MEM/WB pipeline register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         w_valid_q <= 1'b0;
         w_rw_q    <= 1'b0;
         w_reg_q   <= '0;
         w_alu_q   <= '0;
         w_op_q    <= '0;
         w_lane_q  <= '0;
         w_adel_q  <= 1'b0;
         w_ades_q  <= 1'b0;
      end else begin
         w_valid_q <= w_valid_d;
         w_rw_q    <= w_rw_d;
         w_reg_q   <= w_reg_d;
         w_alu_q   <= w_alu_d;
         w_op_q    <= w_op_d;
         w_lane_q  <= w_lane_d;
         w_adel_q  <= w_adel_d;
         w_ades_q  <= w_ades_d;
      end
   end

   assign rd_b = data_sram_rdata[{w_lane_q, 3'b000} +: 8];
   assign rd_h = data_sram_rdata[{w_lane_q[1], 4'b0000} +: 16];

   // Final write value: extended load data or the ALU result.
   always_comb begin
      wb_result = w_alu_q;
      case (w_op_q)
         OP_LB:  wb_result = {{(DATA_W-8){rd_b[7]}}, rd_b};
         OP_LBU: wb_result = {{(DATA_W-8){1'b0}}, rd_b};
         OP_LH:  wb_result = {{(DATA_W-16){rd_h[15]}}, rd_h};
         OP_LHU: wb_result = {{(DATA_W-16){1'b0}}, rd_h};
         OP_LW:  wb_result = data_sram_rdata;
         default: ;
      endcase
   end

   assign wb_valid     = w_valid_q;
   assign wb_regwrite  = w_rw_q;
   assign wb_write_reg = w_reg_q;
   assign exc_adel     = w_valid_q & w_adel_q;
   assign exc_ades     = w_valid_q & w_ades_q;
   assign exc_badvaddr = (exc_adel | exc_ades) ? w_alu_q : '0;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MIPS pipeline memory stage, directly downstream of the execute stage.
- Registers the execute-stage outputs into an EX/MEM pipeline register and drives the single-cycle data SRAM (request issued one cycle, read data returned the next).
- Aligns load data (sign/zero extension) and store data/byte enables, and detects address misalignment.
- Hands a writeback bundle to the WB stage through a MEM/WB register.

Parameters:
- DATA_W, 32, datapath and SRAM data width
- REG_AW, 5, register-file address width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ex_valid  in  1  execute stage presents a valid instruction
- ex_alu_result  in  DATA_W  ALU result / effective address
- ex_store_data  in  DATA_W  rt value for stores
- ex_mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
- ex_write_reg  in  REG_AW  destination register
- ex_regwrite  in  1  instruction writes register file
- stall  in  1  hold MEM register (from hazard unit)
- flush  in  1  kill instruction entering MEM
- data_sram_en  out  1  SRAM access enable
- data_sram_wen  out  4  byte write enables
- data_sram_addr  out  DATA_W  word-aligned address {addr[31:2],2'b00}
- data_sram_wdata  out  DATA_W  lane-replicated store data
- data_sram_rdata  in  DATA_W  read data, valid the cycle after the request
- m_fwd_result  out  DATA_W  MEM-register ALU result, for forwarding
- m_is_load  out  1  MEM register holds a valid load, for load-use hazard detection
- wb_valid  out  1  writeback bundle valid
- wb_regwrite  out  1  write enable to register file
- wb_write_reg  out  REG_AW  destination register
- wb_result  out  DATA_W  final write value
- exc_adel  out  1  load address error, 1-cycle pulse with wb bundle
- exc_ades  out  1  store address error, 1-cycle pulse with wb bundle
- exc_badvaddr  out  DATA_W  faulting address, valid with exc_*

Behaviour:
- Reset: async, active-high. All MEM and WB register fields clear to 0. Every output is 0 during and immediately after reset.
- MEM register update on rising clock:
  - flush=1: load a bubble (valid=0). flush has priority over stall.
  - else stall=1: hold current contents.
  - else: capture ex_* inputs.
- Misalignment is combinational from the MEM register:
  - LH/LHU/SH: addr[0]!=0 is misaligned.
  - LW/SW: addr[1:0]!=0 is misaligned.
  - LB/LBU/SB: never misaligned.
- SRAM request, driven combinationally from the MEM register:
  - data_sram_en=1 iff valid & mem_op in 1..8 & !misaligned & !stall.
  - wen is 0 for loads.
  - SB: wen=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: wen=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}.
  - SW: wen=4'b1111, wdata=data.
  - When en=0: wen=0, wdata=0 and addr=0.
- WB register update on rising clock:
  - stall=1: capture a bubble (valid=0).
  - else: capture MEM valid, write_reg, the ALU result, mem_op, addr[1:0], and the misalignment flags.
  - regwrite is captured as MEM regwrite & !misaligned.
  - flush does not affect the WB register.
- wb_result:
  - Combinational from the WB register and data_sram_rdata.
  - Non-load: the registered ALU result.
  - LB/LBU: byte selected by addr[1:0], sign- or zero-extended.
  - LH/LHU: half selected by addr[1], sign- or zero-extended.
  - LW: rdata.
- Load latency: request in MEM cycle N, wb_result valid in cycle N+1.
- Exceptions:
  - exc_adel/exc_ades = wb_valid & registered misalign flag & load/store type.
  - exc_badvaddr = registered ALU result when either flag is set, else 0.
  - A faulting instruction never writes SRAM or the register file.
- Forwarding outputs: m_fwd_result is the MEM-register ALU result. m_is_load = valid & mem_op in 1..5.
- Stall released: the held instruction issues its SRAM access in the first non-stall cycle, exactly once.
- Stall and flush together: flush wins; the MEM register is bubbled and WB receives a bubble that cycle.
- Reset mid-access: any pending WB load is discarded, and there are no outputs until new instructions arrive.

Test Plan:
- LW at 0x1000_0008, SRAM returns 0xDEAD_BEEF -> en=1, wen=0, addr=0x1000_0008 one cycle after ex_valid; next cycle wb_result=0xDEAD_BEEF, wb_regwrite=1.
- LB at 0x...03, rdata=0x80FF_FF7F -> wb_result=0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- SH of 0x1234_ABCD at 0x...02 -> wen=4'b1100, wdata=0xABCD_ABCD, wb_regwrite=0.
- LW at 0x...06 -> en=0, exc_adel=1, exc_badvaddr=0x...06, wb_regwrite=0. SW at 0x...01 -> exc_ades=1, wen=0.
- SW held by stall=1 for 3 cycles -> en=0 and wb_valid=0 during the stall; exactly one write cycle after release.
- Assert flush together with stall while a LW is in EX -> no SRAM access for it, wb_valid=0. Assert reset mid-load -> all outputs 0 at once.
